cache_controller: RTL and testbench

Direct-mapped, write-through cache controller sitting between the processor port and the cache data RAM (1024 × 32-bit, index = address[9:0]). It holds the tag and valid arrays, decides hit or miss, drives the data RAM's index, write data and write enable, and runs fixed-latency main-memory transactions for read-miss fills and write-through. Read misses allocate a line; write misses do not allocate.

---
 rtl/cache_controller.sv | 136 +++++++++++++
 tb/tb_cache_controller.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Direct-mapped write-through cache controller: tag/valid storage, hit detection,
// data RAM control and fixed-latency main-memory fill / write-through sequencing.
module cache_controller #(
    parameter int WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ProcReq,
    input  logic        ProcRW,
    input  logic [15:0] ProcAddr,
    input  logic [31:0] ProcDataIn,
    output logic [31:0] ProcDataOut,
    output logic        ProcReady,
    output logic        Busy,
    output logic [9:0]  DataRamIndex,
    output logic [31:0] DataRamDataIn,
    output logic        DataRamWrite,
    input  logic [31:0] DataRamDataOut,
    output logic [15:0] MemAddr,
    output logic [31:0] MemDataOut,
    input  logic [31:0] MemDataIn,
    output logic        MemRead,
    output logic        MemWrite
);

    localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_STATES - 1);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, RESP, MEM_READ, FILL, MEM_WRITE
    } state_t;

    state_t         state;
    logic [15:0]    AddrReg;
    logic [31:0]    DataReg;
    logic [31:0]    FillReg;
    logic           RwReg;
    logic           HitReg;
    logic [CW-1:0]  waitCnt;
    logic [1023:0]  Valid;
    logic [5:0]     Tag [1024];
    logic [9:0]     idx;
    logic           hit;

    assign idx = AddrReg[9:0];
    assign hit = Valid[idx] && (Tag[idx] == AddrReg[15:10]);

    assign Busy         = (state != IDLE);
    assign DataRamIndex = idx;
    assign MemAddr      = AddrReg;
    assign MemDataOut   = DataReg;

    // RAM write strobe is decoded from registered state only, so it is stable by the negedge.
    assign DataRamWrite  = (state == FILL) ||
                           (state == MEM_WRITE && HitReg && waitCnt == CNT_INIT);
    assign DataRamDataIn = (state == FILL) ? FillReg : DataReg;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            AddrReg     <= '0;
            DataReg     <= '0;
            FillReg     <= '0;
            RwReg       <= 1'b0;
            HitReg      <= 1'b0;
            waitCnt     <= '0;
            Valid       <= '0;
            ProcDataOut <= '0;
            ProcReady   <= 1'b0;
            MemRead     <= 1'b0;
            MemWrite    <= 1'b0;
        end else begin
            ProcReady <= 1'b0;
            case (state)
                IDLE: begin
                    if (ProcReq) begin
                        AddrReg <= ProcAddr;
                        DataReg <= ProcDataIn;
                        RwReg   <= ProcRW;
                        state   <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    waitCnt <= CNT_INIT;
                    HitReg  <= hit;
                    if (!RwReg) begin
                        MemWrite <= 1'b1;
                        state    <= MEM_WRITE;
                    end else if (hit) begin
                        state <= RESP;
                    end else begin
                        MemRead <= 1'b1;
                        state   <= MEM_READ;
                    end
                end
                RESP: begin
                    ProcDataOut <= DataRamDataOut;
                    ProcReady   <= 1'b1;
                    state       <= IDLE;
                end
                MEM_READ: begin
                    if (waitCnt == '0) begin
                        MemRead <= 1'b0;
                        FillReg <= MemDataIn;
                        state   <= FILL;
                    end else begin
                        waitCnt <= waitCnt - 1'b1;
                    end
                end
                FILL: begin
                    Valid[idx]  <= 1'b1;
                    ProcDataOut <= FillReg;
                    ProcReady   <= 1'b1;
                    state       <= IDLE;
                end
                MEM_WRITE: begin
                    if (waitCnt == '0) begin
                        MemWrite  <= 1'b0;
                        ProcReady <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        waitCnt <= waitCnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag storage is deliberately not reset; Valid alone qualifies it.
    always_ff @(posedge Clk) begin
        if (!Reset && state == FILL)
            Tag[idx] <= AddrReg[15:10];
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with behavioural data RAM and main memory.
module tb_cache_controller;
    localparam int W = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ProcReq;
    logic        ProcRW;
    logic [15:0] ProcAddr;
    logic [31:0] ProcDataIn;
    logic [31:0] ProcDataOut;
    logic        ProcReady;
    logic        Busy;
    logic [9:0]  DataRamIndex;
    logic [31:0] DataRamDataIn;
    logic        DataRamWrite;
    logic [31:0] DataRamDataOut;
    logic [15:0] MemAddr;
    logic [31:0] MemDataOut;
    logic [31:0] MemDataIn;
    logic        MemRead;
    logic        MemWrite;

    always #5 Clk = ~Clk;

    cache_controller #(.WAIT_STATES(W)) dut (
        .Clk(Clk), .Reset(Reset), .ProcReq(ProcReq), .ProcRW(ProcRW),
        .ProcAddr(ProcAddr), .ProcDataIn(ProcDataIn), .ProcDataOut(ProcDataOut),
        .ProcReady(ProcReady), .Busy(Busy), .DataRamIndex(DataRamIndex),
        .DataRamDataIn(DataRamDataIn), .DataRamWrite(DataRamWrite),
        .DataRamDataOut(DataRamDataOut), .MemAddr(MemAddr), .MemDataOut(MemDataOut),
        .MemDataIn(MemDataIn), .MemRead(MemRead), .MemWrite(MemWrite)
    );

    logic [31:0] dataRam [1024];
    logic [31:0] mainMem [65536];

    always @(negedge Clk) if (DataRamWrite) dataRam[DataRamIndex] <= DataRamDataIn;
    always @(posedge Clk) DataRamDataOut <= dataRam[DataRamIndex];
    always @(negedge Clk) if (MemWrite) mainMem[MemAddr] <= MemDataOut;
    assign MemDataIn = mainMem[MemAddr];

    int errors = 0;
    int checks = 0;

    // Per-request observations, filled by issue().
    int          rdy, rdyAfter, nRd, rd1, nWr, wr1, nRam, ram1;
    logic [9:0]  ramIdx;
    logic [31:0] ramDat;
    logic [15:0] mAddr;

    task automatic issue(input logic rw, input logic [15:0] addr, input logic [31:0] din);
        rdy = -1; rdyAfter = -1; nRd = 0; rd1 = -1; nWr = 0; wr1 = -1; nRam = 0; ram1 = -1;
        ramIdx = '0; ramDat = '0; mAddr = '0;
        @(negedge Clk);
        ProcReq = 1'b1; ProcRW = rw; ProcAddr = addr; ProcDataIn = din;
        @(posedge Clk);
        @(negedge Clk);
        ProcReq = 1'b0; ProcAddr = ~addr; ProcDataIn = ~din;
        for (int k = 1; k <= 30; k++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (MemRead) begin nRd++; if (rd1 < 0) rd1 = k; mAddr = MemAddr; end
            if (MemWrite) begin nWr++; if (wr1 < 0) wr1 = k; mAddr = MemAddr; end
            if (DataRamWrite) begin
                nRam++; if (ram1 < 0) ram1 = k;
                ramIdx = DataRamIndex; ramDat = DataRamDataIn;
            end
            if (ProcReady) begin rdy = k; break; end
        end
        @(posedge Clk);
        @(negedge Clk);
        rdyAfter = int'(ProcReady);
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checks++; if (ProcReady !== 1'b0) begin errors++; $display("FAIL reset_ready got=%0b want=0", ProcReady); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b want=0", Busy); end
        checks++; if ({MemRead, MemWrite, DataRamWrite} !== 3'b000) begin errors++; $display("FAIL reset_strobes got=%b want=000", {MemRead, MemWrite, DataRamWrite}); end
        checks++; if (ProcDataOut !== 32'h0) begin errors++; $display("FAIL reset_dataout got=%h want=0", ProcDataOut); end
        checks++; if (MemAddr !== 16'h0 || MemDataOut !== 32'h0) begin errors++; $display("FAIL reset_regs got=%h/%h want=0/0", MemAddr, MemDataOut); end
        Reset = 1'b0;
    endtask

    task automatic test_read_miss;
        issue(1'b1, 16'h0404, 32'h0);
        checks++; if (nRd !== 2 || rd1 !== 1) begin errors++; $display("FAIL rmiss_memread cnt=%0d first=%0d want 2/1", nRd, rd1); end
        checks++; if (mAddr !== 16'h0404) begin errors++; $display("FAIL rmiss_memaddr got=%h want=0404", mAddr); end
        checks++; if (nRam !== 1 || ram1 !== 3) begin errors++; $display("FAIL rmiss_ramwr cnt=%0d edge=%0d want 1/3", nRam, ram1); end
        checks++; if (ramIdx !== 10'h004 || ramDat !== 32'hDEADBEEF) begin errors++; $display("FAIL rmiss_ramfill got=%h/%h want 004/deadbeef", ramIdx, ramDat); end
        checks++; if (rdy !== 4) begin errors++; $display("FAIL rmiss_ready edge got=%0d want=4", rdy); end
        checks++; if (ProcDataOut !== 32'hDEADBEEF) begin errors++; $display("FAIL rmiss_data got=%h want=deadbeef", ProcDataOut); end
        checks++; if (rdyAfter !== 0) begin errors++; $display("FAIL rmiss_pulse got=%0d want=0", rdyAfter); end
    endtask

    task automatic test_read_hit;
        issue(1'b1, 16'h0404, 32'h0);
        checks++; if (nRd !== 0 || nRam !== 0) begin errors++; $display("FAIL rhit_nomem rd=%0d ram=%0d want 0/0", nRd, nRam); end
        checks++; if (rdy !== 2) begin errors++; $display("FAIL rhit_ready edge got=%0d want=2", rdy); end
        checks++; if (ProcDataOut !== 32'hDEADBEEF) begin errors++; $display("FAIL rhit_data got=%h want=deadbeef", ProcDataOut); end
    endtask

    task automatic test_same_index;
        issue(1'b1, 16'h0804, 32'h0);
        checks++; if (nRd !== 2 || rdy !== 4) begin errors++; $display("FAIL conflict_miss rd=%0d rdy=%0d want 2/4", nRd, rdy); end
        checks++; if (ProcDataOut !== 32'hCAFE0804) begin errors++; $display("FAIL conflict_data got=%h want=cafe0804", ProcDataOut); end
        issue(1'b1, 16'h0404, 32'h0);
        checks++; if (nRd !== 2 || rdy !== 4) begin errors++; $display("FAIL evicted_miss rd=%0d rdy=%0d want 2/4", nRd, rdy); end
        checks++; if (ProcDataOut !== 32'hDEADBEEF) begin errors++; $display("FAIL evicted_data got=%h want=deadbeef", ProcDataOut); end
    endtask

    task automatic test_write;
        issue(1'b1, 16'h0804, 32'h0);
        issue(1'b0, 16'h0804, 32'h12345678);
        checks++; if (nWr !== 2 || wr1 !== 1 || nRd !== 0) begin errors++; $display("FAIL whit_memwrite cnt=%0d first=%0d rd=%0d want 2/1/0", nWr, wr1, nRd); end
        checks++; if (nRam !== 1 || ram1 !== 1) begin errors++; $display("FAIL whit_ramwr cnt=%0d edge=%0d want 1/1", nRam, ram1); end
        checks++; if (ramIdx !== 10'h004 || ramDat !== 32'h12345678) begin errors++; $display("FAIL whit_ramdata got=%h/%h want 004/12345678", ramIdx, ramDat); end
        checks++; if (rdy !== 3) begin errors++; $display("FAIL whit_ready edge got=%0d want=3", rdy); end
        checks++; if (ProcDataOut !== 32'hCAFE0804) begin errors++; $display("FAIL whit_dataout_held got=%h want=cafe0804", ProcDataOut); end
        checks++; if (mainMem[16'h0804] !== 32'h12345678) begin errors++; $display("FAIL whit_through got=%h want=12345678", mainMem[16'h0804]); end
        issue(1'b1, 16'h0804, 32'h0);
        checks++; if (nRd !== 0 || rdy !== 2) begin errors++; $display("FAIL whit_reread rd=%0d rdy=%0d want 0/2", nRd, rdy); end
        checks++; if (ProcDataOut !== 32'h12345678) begin errors++; $display("FAIL whit_reread_data got=%h want=12345678", ProcDataOut); end
        issue(1'b0, 16'h1004, 32'h55AA55AA);
        checks++; if (nWr !== 2 || nRam !== 0 || rdy !== 3) begin errors++; $display("FAIL wmiss wr=%0d ram=%0d rdy=%0d want 2/0/3", nWr, nRam, rdy); end
        issue(1'b1, 16'h1004, 32'h0);
        checks++; if (nRd !== 2 || rdy !== 4) begin errors++; $display("FAIL wmiss_noalloc rd=%0d rdy=%0d want 2/4", nRd, rdy); end
        checks++; if (ProcDataOut !== 32'h55AA55AA) begin errors++; $display("FAIL wmiss_readback got=%h want=55aa55aa", ProcDataOut); end
    endtask

    task automatic test_reset_mid;
        int stray;
        stray = 0;
        @(negedge Clk);
        ProcReq = 1'b1; ProcRW = 1'b1; ProcAddr = 16'h0404;
        @(posedge Clk);
        @(negedge Clk); ProcReq = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        checks++; if (MemRead !== 1'b1) begin errors++; $display("FAIL rstmid_memread_on got=%0b want=1", MemRead); end
        @(posedge Clk);
        @(negedge Clk); Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        checks++; if ({MemRead, MemWrite, DataRamWrite, ProcReady, Busy} !== 5'b0) begin errors++; $display("FAIL rstmid_idle got=%b want=00000", {MemRead, MemWrite, DataRamWrite, ProcReady, Busy}); end
        Reset = 1'b0;
        repeat (4) begin @(posedge Clk); @(negedge Clk); if (ProcReady || Busy) stray++; end
        checks++; if (stray !== 0) begin errors++; $display("FAIL rstmid_quiet got=%0d want=0", stray); end
        issue(1'b1, 16'h1004, 32'h0);
        checks++; if (nRd !== 2) begin errors++; $display("FAIL rstmid_valid_cleared rd=%0d want=2", nRd); end
        issue(1'b1, 16'h0404, 32'h0);
        checks++; if (nRd !== 2 || ProcDataOut !== 32'hDEADBEEF) begin errors++; $display("FAIL rstmid_refill rd=%0d data=%h want 2/deadbeef", nRd, ProcDataOut); end
    endtask

    task automatic test_back_to_back;
        logic        rws  [4];
        logic [15:0] adrs [4];
        logic [31:0] dats [4];
        int          edges [4];
        int          want  [4];
        int          n, rdCnt, wrCnt;
        rws[0] = 1'b1; adrs[0] = 16'h0404; dats[0] = 32'h0;
        rws[1] = 1'b0; adrs[1] = 16'h0404; dats[1] = 32'h0BADF00D;
        rws[2] = 1'b1; adrs[2] = 16'h0404; dats[2] = 32'h0;
        rws[3] = 1'b0; adrs[3] = 16'h2008; dats[3] = 32'h11112222;
        want[0] = 2; want[1] = 6; want[2] = 9; want[3] = 13;
        for (int i = 0; i < 4; i++) edges[i] = -1;
        n = 0; rdCnt = 0; wrCnt = 0;
        @(negedge Clk);
        ProcReq = 1'b1; ProcRW = rws[0]; ProcAddr = adrs[0]; ProcDataIn = dats[0];
        for (int k = 0; k < 40 && n < 4; k++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (MemRead) rdCnt++;
            if (MemWrite) wrCnt++;
            if (ProcReady) begin
                edges[n] = k;
                n++;
                if (n == 3) begin
                    checks++; if (ProcDataOut !== 32'h0BADF00D) begin errors++; $display("FAIL b2b_read_data got=%h want=0badf00d", ProcDataOut); end
                end
                if (n < 4) begin ProcRW = rws[n]; ProcAddr = adrs[n]; ProcDataIn = dats[n]; end
                else ProcReq = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (edges[i] !== want[i]) begin errors++; $display("FAIL b2b_ready_%0d edge got=%0d want=%0d", i, edges[i], want[i]); end
        end
        checks++; if (rdCnt !== 0 || wrCnt !== 4) begin errors++; $display("FAIL b2b_memops rd=%0d wr=%0d want 0/4", rdCnt, wrCnt); end
        checks++; if (mainMem[16'h2008] !== 32'h11112222 || mainMem[16'h0404] !== 32'h0BADF00D) begin errors++; $display("FAIL b2b_through got=%h/%h want 11112222/0badf00d", mainMem[16'h2008], mainMem[16'h0404]); end
        checks++; if (ProcDataOut !== 32'h0BADF00D) begin errors++; $display("FAIL b2b_dataout_held got=%h want=0badf00d", ProcDataOut); end
        @(posedge Clk);
        @(negedge Clk);
        checks++; if (Busy !== 1'b0 || ProcReady !== 1'b0) begin errors++; $display("FAIL b2b_no_dup busy=%0b rdy=%0b want 0/0", Busy, ProcReady); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mainMem[i] = {16'hC0DE, 16'(i)};
        mainMem[16'h0404] = 32'hDEADBEEF;
        mainMem[16'h0804] = 32'hCAFE0804;
        ProcReq = 1'b0; ProcRW = 1'b1; ProcAddr = '0; ProcDataIn = '0;
        test_reset;
        test_read_miss;
        test_read_hit;
        test_same_index;
        test_write;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
